// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the sequential signed divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract iteration on unsigned magnitudes
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] sh;
    logic           ge;
    // compare in WIDTH+1 bits so the shifted-out remainder MSB is never lost
    always_comb begin
        sh    = {rem, quo[WIDTH-1]};
        ge    = sh >= {1'b0, dvs};
        rem_n = ge ? WIDTH'(sh - {1'b0, dvs}) : WIDTH'(sh);
        quo_n = {quo[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: multicycle signed divider, quotient to div_lo, remainder to div_hi
module div_seq_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_zero,
    output logic             div_finished,
    output logic             busy,
    output logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] div_hi
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n, quo, quo_n, dvs, dvs_n;
    logic [WIDTH-1:0] step_rem, step_quo, lo_n, hi_n;
    logic             sign_q, sign_q_n, sign_r, sign_r_n, zero_n, fin_n;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dvs   (dvs),
        .rem_n (step_rem),
        .quo_n (step_quo)
    );

    assign busy = state != IDLE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            div_lo       <= '0;
            div_hi       <= '0;
            div_zero     <= 1'b0;
            div_finished <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rem          <= rem_n;
            quo          <= quo_n;
            dvs          <= dvs_n;
            sign_q       <= sign_q_n;
            sign_r       <= sign_r_n;
            div_lo       <= lo_n;
            div_hi       <= hi_n;
            div_zero     <= zero_n;
            div_finished <= fin_n;
        end
    end

    // a start coinciding with the finish pulse is dropped; the next IDLE cycle may accept
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        lo_n     = div_lo;
        hi_n     = div_hi;
        zero_n   = 1'b0;
        fin_n    = 1'b0;
        case (state)
            IDLE: begin
                if (div_start && !div_finished) begin
                    if (divisor == '0) begin
                        zero_n = 1'b1;
                    end else begin
                        state_n  = RUN;
                        cnt_n    = CW'(WIDTH - 1);
                        rem_n    = '0;
                        quo_n    = dividend[WIDTH-1] ? -dividend : dividend;
                        dvs_n    = divisor[WIDTH-1] ? -divisor : divisor;
                        sign_q_n = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_n = dividend[WIDTH-1];
                    end
                end
            end
            RUN: begin
                rem_n   = step_rem;
                quo_n   = step_quo;
                cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
                state_n = cnt == '0 ? DONE : RUN;
            end
            DONE: begin
                lo_n    = sign_q ? -quo : quo;
                hi_n    = sign_r ? -rem : rem;
                fin_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
